// File: rtl/pipe_skid_reg.sv
// ----------------------------------------------------------------------------
// pipe_skid_reg
// Two-entry pipeline skid buffer (main + skid register) for a pipeline stage
// boundary. The main register feeds the downstream stage directly. The skid
// register catches the one entry that can arrive while downstream stalls, so
// in_ready can be a registered signal without losing data.
//
// Ports
//   clk        clock; all state updates on the rising edge
//   reset      asynchronous, active-high reset
//   in_valid   upstream presents an entry
//   in_ready   registered; the block can accept an entry this cycle
//   in_data    upstream payload (DATA_W)
//   in_ctrl    upstream control bits (CTRL_W)
//   flush      synchronous kill of every held entry
//   out_valid  an entry is presented downstream
//   out_ready  downstream accepts the presented entry
//   out_data   presented payload; keeps its last value while out_valid is low
//   out_ctrl   presented control bits; all-zero while out_valid is low
//   occupancy  number of held entries, 0..2
// ----------------------------------------------------------------------------
module pipe_skid_reg #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occupancy
);

   // The encoding doubles as the occupancy count.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t            state_reg, state_next;
   logic [DATA_W-1:0] main_data_reg, main_data_next;
   logic [CTRL_W-1:0] main_ctrl_reg, main_ctrl_next;
   logic [DATA_W-1:0] skid_data_reg, skid_data_next;
   logic [CTRL_W-1:0] skid_ctrl_reg, skid_ctrl_next;
   logic              in_ready_reg, in_ready_next;

   logic in_fire;
   logic out_fire;

   assign out_valid = (state_reg != EMPTY);
   assign in_fire   = in_valid && in_ready_reg;
   assign out_fire  = out_valid && out_ready;

   always_comb begin
      state_next     = state_reg;
      main_data_next = main_data_reg;
      main_ctrl_next = main_ctrl_reg;
      skid_data_next = skid_data_reg;
      skid_ctrl_next = skid_ctrl_reg;

      if (flush) begin
         // Flush wins over any simultaneous in-transfer; the payload field is
         // left alone so out_data simply keeps its last value.
         state_next     = EMPTY;
         main_ctrl_next = '0;
         skid_ctrl_next = '0;
      end else begin
         case (state_reg)
            EMPTY: begin
               if (in_fire) begin
                  state_next     = ONE;
                  main_data_next = in_data;
                  main_ctrl_next = in_ctrl;
               end
            end
            ONE: begin
               case ({in_fire, out_fire})
                  2'b11: begin
                     main_data_next = in_data;
                     main_ctrl_next = in_ctrl;
                  end
                  2'b10: begin
                     state_next     = FULL;
                     skid_data_next = in_data;
                     skid_ctrl_next = in_ctrl;
                  end
                  2'b01: begin
                     // Leaving for a bubble: control goes to zero so the
                     // downstream stage never sees stale RegWrite etc.
                     state_next     = EMPTY;
                     main_ctrl_next = '0;
                  end
                  default: ;
               endcase
            end
            FULL: begin
               // in_ready is low here, so only the drain case can occur.
               if (out_fire) begin
                  state_next     = ONE;
                  main_data_next = skid_data_reg;
                  main_ctrl_next = skid_ctrl_reg;
                  skid_ctrl_next = '0;
               end
            end
            default: begin
               state_next     = EMPTY;
               main_ctrl_next = '0;
               skid_ctrl_next = '0;
            end
         endcase
      end

      // Registered ready: it reflects the state being entered, so it is
      // already correct in the cycle that state becomes current.
      in_ready_next = (state_next != FULL);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= EMPTY;
         main_data_reg <= '0;
         main_ctrl_reg <= '0;
         skid_data_reg <= '0;
         skid_ctrl_reg <= '0;
         in_ready_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         main_data_reg <= main_data_next;
         main_ctrl_reg <= main_ctrl_next;
         skid_data_reg <= skid_data_next;
         skid_ctrl_reg <= skid_ctrl_next;
         in_ready_reg  <= in_ready_next;
      end
   end

   assign in_ready  = in_ready_reg;
   assign out_data  = main_data_reg;
   assign out_ctrl  = main_ctrl_reg;
   assign occupancy = state_reg;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// ----------------------------------------------------------------------------
// tb_pipe_skid_reg
// Directed tests of pipe_skid_reg plus a random run against a queue model.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// ----------------------------------------------------------------------------
module tb_pipe_skid_reg;

   localparam int DATA_W = 32;
   localparam int CTRL_W = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [CTRL_W-1:0] in_ctrl;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CTRL_W-1:0] out_ctrl;
   logic [1:0]        occupancy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipe_skid_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_ctrl   (in_ctrl),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ctrl  (out_ctrl),
      .occupancy (occupancy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [DATA_W-1:0] d,
                        input logic [CTRL_W-1:0] c);
      in_valid = v;
      in_data  = d;
      in_ctrl  = c;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
      flush = 1'b0; out_ready = 1'b0;
      #12;
      checks++;
      if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b0 ||
          out_data !== '0 || out_ctrl !== '0) begin
         errors++;
         $display("FAIL reset_state: valid=%b occ=%0d rdy=%b data=%h ctrl=%h, want 0 0 0 0 0",
                  out_valid, occupancy, in_ready, out_data, out_ctrl);
      end
      @(negedge clk);
      reset = 1'b0;
      step();
      checks++;
      if (in_ready !== 1'b1 || occupancy !== 2'd0) begin
         errors++;
         $display("FAIL reset_release: rdy=%b occ=%0d, want 1 0", in_ready, occupancy);
      end
      $display("test_reset done");
   endtask

   task automatic test_pass_through();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'h11 + i, 8'(i + 1));
         step();
         checks++;
         if (out_valid !== 1'b1 || out_data !== 32'h11 + i ||
             out_ctrl !== 8'(i + 1) || occupancy !== 2'd1) begin
            errors++;
            $display("FAIL pass_through[%0d]: valid=%b data=%h ctrl=%h occ=%0d, want 1 %h %h 1",
                     i, out_valid, out_data, out_ctrl, occupancy, 32'h11 + i, 8'(i + 1));
         end
      end
      drive(1'b0, '0, '0);
      step();
      checks++;
      if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_ctrl !== 8'h00) begin
         errors++;
         $display("FAIL pass_through_drain: valid=%b occ=%0d ctrl=%h, want 0 0 00",
                  out_valid, occupancy, out_ctrl);
      end
      $display("test_pass_through done");
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      drive(1'b1, 32'hA1, 8'h01); step();
      drive(1'b1, 32'hA2, 8'h02); step();
      checks++;
      if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'hA1) begin
         errors++;
         $display("FAIL bp_full: occ=%0d rdy=%b data=%h, want 2 0 a1",
                  occupancy, in_ready, out_data);
      end
      drive(1'b1, 32'hA3, 8'h03); step();
      checks++;
      if (occupancy !== 2'd2 || out_data !== 32'hA1 || out_ctrl !== 8'h01) begin
         errors++;
         $display("FAIL bp_stall_stable: occ=%0d data=%h ctrl=%h, want 2 a1 01",
                  occupancy, out_data, out_ctrl);
      end
      out_ready = 1'b1; step();
      checks++;
      if (out_data !== 32'hA2 || occupancy !== 2'd1 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_drain1: data=%h occ=%0d rdy=%b, want a2 1 1",
                  out_data, occupancy, in_ready);
      end
      step();
      checks++;
      if (out_data !== 32'hA3 || out_ctrl !== 8'h03 || occupancy !== 2'd1) begin
         errors++;
         $display("FAIL bp_drain2: data=%h ctrl=%h occ=%0d, want a3 03 1",
                  out_data, out_ctrl, occupancy);
      end
      drive(1'b0, '0, '0); step();
      checks++;
      if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
         errors++;
         $display("FAIL bp_empty: valid=%b occ=%0d, want 0 0", out_valid, occupancy);
      end
      $display("test_backpressure done");
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      drive(1'b1, 32'hB1, 8'h11); step();
      drive(1'b1, 32'hB2, 8'h12); step();
      drive(1'b1, 32'hB3, 8'h13); flush = 1'b1; step();
      checks++;
      if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || occupancy !== 2'd0 ||
          in_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush_full: valid=%b ctrl=%h occ=%0d rdy=%b, want 0 00 0 1",
                  out_valid, out_ctrl, occupancy, in_ready);
      end
      flush = 1'b0; drive(1'b0, '0, '0); out_ready = 1'b1; step();
      checks++;
      if (out_valid !== 1'b0 || out_data === 32'hB3) begin
         errors++;
         $display("FAIL flush_discard: valid=%b data=%h, want valid 0 and no b3",
                  out_valid, out_data);
      end
      $display("test_flush done");
   endtask

   task automatic test_bubble();
      out_ready = 1'b1;
      drive(1'b1, 32'hC1, 8'h5A); step();
      checks++;
      if (out_valid !== 1'b1 || out_ctrl !== 8'h5A || out_data !== 32'hC1) begin
         errors++;
         $display("FAIL bubble_entry: valid=%b ctrl=%h data=%h, want 1 5a c1",
                  out_valid, out_ctrl, out_data);
      end
      drive(1'b0, 32'hDEAD, 8'hFF); step();
      checks++;
      if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || out_data !== 32'hC1) begin
         errors++;
         $display("FAIL bubble_zero_ctrl: valid=%b ctrl=%h data=%h, want 0 00 c1",
                  out_valid, out_ctrl, out_data);
      end
      $display("test_bubble done");
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 32'h100 + i, 8'(8'h20 + i));
         step();
         checks++;
         if (out_data !== 32'h100 + i || in_ready !== 1'b1 || occupancy !== 2'd1) begin
            errors++;
            $display("FAIL back_to_back[%0d]: data=%h rdy=%b occ=%0d, want %h 1 1",
                     i, out_data, in_ready, occupancy, 32'h100 + i);
         end
      end
      drive(1'b0, '0, '0); step();
      $display("test_back_to_back done");
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      drive(1'b1, 32'hD1, 8'h31); step();
      drive(1'b1, 32'hD2, 8'h32); step();
      drive(1'b0, '0, '0);
      checks++;
      if (occupancy !== 2'd2) begin
         errors++;
         $display("FAIL async_fill: occ=%0d, want 2", occupancy);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b0 ||
          out_data !== '0 || out_ctrl !== '0) begin
         errors++;
         $display("FAIL async_reset: valid=%b occ=%0d rdy=%b data=%h ctrl=%h, want 0 0 0 0 0",
                  out_valid, occupancy, in_ready, out_data, out_ctrl);
      end
      @(negedge clk);
      reset = 1'b0;
      out_ready = 1'b1;
      step();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL async_release: rdy=%b valid=%b, want 1 0", in_ready, out_valid);
      end
      $display("test_async_reset done");
   endtask

   task automatic test_random();
      logic [DATA_W-1:0] q_data[$];
      logic [CTRL_W-1:0] q_ctrl[$];
      logic in_fire, out_fire;
      int err_start;
      err_start = errors;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         flush     = ($urandom_range(0, 19) == 0);
         in_data   = $urandom;
         in_ctrl   = 8'($urandom_range(1, 255));
         in_fire   = in_valid && in_ready;
         out_fire  = out_valid && out_ready;
         step();
         if (flush) begin
            q_data.delete();
            q_ctrl.delete();
         end else begin
            if (out_fire && q_data.size() > 0) begin
               void'(q_data.pop_front());
               void'(q_ctrl.pop_front());
            end
            if (in_fire) begin
               q_data.push_back(in_data);
               q_ctrl.push_back(in_ctrl);
            end
         end
         checks++;
         if (occupancy !== 2'(q_data.size()) || out_valid !== (q_data.size() != 0) ||
             in_ready !== (q_data.size() < 2)) begin
            errors++;
            $display("FAIL random_state[%0d]: occ=%0d valid=%b rdy=%b, want occ %0d",
                     cyc, occupancy, out_valid, in_ready, q_data.size());
         end
         checks++;
         if (q_data.size() != 0) begin
            if (out_data !== q_data[0] || out_ctrl !== q_ctrl[0]) begin
               errors++;
               $display("FAIL random_front[%0d]: data=%h ctrl=%h, want %h %h",
                        cyc, out_data, out_ctrl, q_data[0], q_ctrl[0]);
            end
         end else if (out_ctrl !== '0) begin
            errors++;
            $display("FAIL random_bubble[%0d]: ctrl=%h, want 00", cyc, out_ctrl);
         end
      end
      flush = 1'b0; drive(1'b0, '0, '0);
      $display("test_random done: %0d new errors", errors - err_start);
   endtask

   initial begin
      test_reset();
      test_pass_through();
      test_backpressure();
      test_flush();
      test_bubble();
      test_back_to_back();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
